// File: rtl/line_mem_responder_if.sv
// Line-transfer channel between the data cache and its memory-side responder.
// Carries the request handshake, the writeback beat channel and the fill beat
// channel. Clock and reset are kept outside as plain ports.
interface line_mem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] wdata;
   logic        wvalid;
   logic        wready;
   logic [31:0] rdata;
   logic        rvalid;
   logic        rready;
   logic        rlast;
   logic        done;

   // Cache side: issues requests, sources writeback beats, sinks fill beats.
   modport master (
      output req_valid, req_we, req_addr, wdata, wvalid, rready,
      input  req_ready, wready, rdata, rvalid, rlast, done
   );

   // Memory side: accepts requests, sinks writeback beats, sources fill beats.
   modport slave (
      input  req_valid, req_we, req_addr, wdata, wvalid, rready,
      output req_ready, wready, rdata, rvalid, rlast, done
   );
endinterface

// File: rtl/line_mem_responder.sv
// Memory-side responder for the 2-way data cache. Serves 256-bit line fills and
// dirty-line writebacks as 8 x 32-bit beats from an internal word array, after
// a fixed programmable access latency. All outputs are registered.
module line_mem_responder #(
   parameter int ADDR_WORDS_LOG2 = 12,
   parameter int LATENCY         = 4,
   parameter int LINE_WORDS      = 8
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   line_mem_responder_if.slave  bus
);

   localparam int DATA_W = 32;
   localparam int BEAT_W = $clog2(LINE_WORDS);
   localparam int LINE_W = ADDR_WORDS_LOG2 - BEAT_W;
   localparam int DEPTH  = 1 << ADDR_WORDS_LOG2;

   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
   localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
   localparam logic [3:0]        LAT_INIT  = 4'(LATENCY - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_RBURST,
      S_WBURST,
      S_DONE
   } state_t;

   // Backing store; deliberately untouched by reset.
   logic [DATA_W-1:0] mem [DEPTH];

   state_t              state_q,     state_d;
   logic [3:0]          lat_q,       lat_d;
   logic [BEAT_W-1:0]   beat_q,      beat_d;
   logic [LINE_W-1:0]   line_q,      line_d;
   logic                we_q,        we_d;
   logic                req_ready_q, req_ready_d;
   logic                wready_q,    wready_d;
   logic                rvalid_q,    rvalid_d;
   logic                rlast_q,     rlast_d;
   logic                done_q,      done_d;
   logic [DATA_W-1:0]   rdata_q,     rdata_d;

   logic [BEAT_W-1:0]   beat_nxt;
   logic                mem_we;

   // Byte-offset bits and address bits beyond the array alias away.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{bus.req_addr[31:ADDR_WORDS_LOG2+2],
                               bus.req_addr[BEAT_W+1:0]};

   assign beat_nxt = beat_q + BEAT_ONE;

   // Next-state, next-output and array-write decode for the request sequencer.
   always_comb begin
      state_d     = state_q;
      lat_d       = lat_q;
      beat_d      = beat_q;
      line_d      = line_q;
      we_d        = we_q;
      req_ready_d = req_ready_q;
      wready_d    = wready_q;
      rvalid_d    = rvalid_q;
      rlast_d     = rlast_q;
      rdata_d     = rdata_q;
      done_d      = 1'b0;
      mem_we      = 1'b0;

      case (state_q)
         S_IDLE: begin
            req_ready_d = 1'b1;
            // req_ready_q gates acceptance so the first cycle after reset is idle.
            if (bus.req_valid && req_ready_q) begin
               req_ready_d = 1'b0;
               line_d      = bus.req_addr[ADDR_WORDS_LOG2+1:BEAT_W+2];
               we_d        = bus.req_we;
               lat_d       = LAT_INIT;
               beat_d      = '0;
               state_d     = S_WAIT;
            end
         end

         S_WAIT: begin
            if (lat_q == 4'd0) begin
               beat_d = '0;
               if (we_q) begin
                  wready_d = 1'b1;
                  state_d  = S_WBURST;
               end else begin
                  // Beat 0 is fetched here so it is on rdata the cycle rvalid rises.
                  rvalid_d = 1'b1;
                  rlast_d  = 1'b0;
                  rdata_d  = mem[{line_q, {BEAT_W{1'b0}}}];
                  state_d  = S_RBURST;
               end
            end else begin
               lat_d = lat_q - 4'd1;
            end
         end

         S_RBURST: begin
            if (rvalid_q && bus.rready) begin
               if (beat_q == LAST_BEAT) begin
                  rvalid_d = 1'b0;
                  rlast_d  = 1'b0;
                  rdata_d  = '0;
                  done_d   = 1'b1;
                  state_d  = S_DONE;
               end else begin
                  // Prefetch the next beat on the handshake; otherwise hold steady.
                  beat_d  = beat_nxt;
                  rdata_d = mem[{line_q, beat_nxt}];
                  rlast_d = (beat_nxt == LAST_BEAT);
               end
            end
         end

         S_WBURST: begin
            if (bus.wvalid && wready_q) begin
               mem_we = 1'b1;
               if (beat_q == LAST_BEAT) begin
                  wready_d = 1'b0;
                  done_d   = 1'b1;
                  state_d  = S_DONE;
               end else begin
                  beat_d = beat_nxt;
               end
            end
         end

         S_DONE: begin
            req_ready_d = 1'b1;
            state_d     = S_IDLE;
         end

         default: begin
            state_d     = S_IDLE;
            req_ready_d = 1'b0;
            wready_d    = 1'b0;
            rvalid_d    = 1'b0;
            rlast_d     = 1'b0;
            rdata_d     = '0;
         end
      endcase
   end

   // Sequencer state, counters and registered outputs; reset is asynchronous.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= S_IDLE;
         lat_q       <= '0;
         beat_q      <= '0;
         req_ready_q <= 1'b0;
         wready_q    <= 1'b0;
         rvalid_q    <= 1'b0;
         rlast_q     <= 1'b0;
         done_q      <= 1'b0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         lat_q       <= lat_d;
         beat_q      <= beat_d;
         req_ready_q <= req_ready_d;
         wready_q    <= wready_d;
         rvalid_q    <= rvalid_d;
         rlast_q     <= rlast_d;
         done_q      <= done_d;
         rdata_q     <= rdata_d;
      end
   end

   // Request attributes latched at acceptance; meaningless in IDLE, so no reset.
   always_ff @(posedge CLK) begin
      line_q <= line_d;
      we_q   <= we_d;
   end

   // Writeback beat into the array; only fires while wready is up in WBURST.
   always_ff @(posedge CLK) begin
      if (mem_we) begin
         mem[{line_q, beat_q}] <= bus.wdata;
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.wready    = wready_q;
   assign bus.rvalid    = rvalid_q;
   assign bus.rlast     = rlast_q;
   assign bus.rdata     = rdata_q;
   assign bus.done      = done_q;

endmodule

// File: tb/tb_line_mem_responder.sv
// Randomized bench for line_mem_responder with a word-level memory model.
module tb_line_mem_responder;

   localparam int LAT = 4;
   localparam int AW  = 12;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;

   // Reference memory: word index -> last written value.
   logic [31:0] ref_mem [int];

   line_mem_responder_if bus();

   line_mem_responder #(
      .ADDR_WORDS_LOG2(AW),
      .LATENCY        (LAT),
      .LINE_WORDS     (8)
   ) dut (
      .CLK  (clk),
      .RST_N(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Word index of beat k of the line holding byte address addr.
   function automatic int widx(input logic [31:0] addr, input int k);
      return int'(((addr / 32) * 8 + 32'(k)) % (32'd1 << AW));
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_req(input logic we, input logic [31:0] addr, output int acc);
      int guard;
      guard = 0;
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = addr;
      while (bus.req_ready !== 1'b1 && guard < 50) begin
         step();
         guard++;
      end
      chk("req_ready_wait", 32'(guard < 50), 32'd1);
      step();
      acc = cyc;
   endtask

   task automatic write_line(input logic [31:0] addr, input logic [31:0] data [8],
                             input int gaps [8]);
      int   acc, k, guard, gap_left;
      logic fire;
      send_req(1'b1, addr, acc);
      bus.req_valid = 1'b0;
      for (int c = 1; c <= LAT; c++) begin
         chk("wait_wready", 32'(bus.wready), 32'd0);
         chk("wait_req_ready", 32'(bus.req_ready), 32'd0);
         bus.wvalid = 1'b1;
         bus.wdata  = 32'hDEAD_0000 | 32'(c);
         step();
      end
      bus.wvalid = 1'b0;
      chk("wready_first", 32'(bus.wready), 32'd1);
      k = 0;
      guard = 0;
      gap_left = gaps[0];
      while (k < 8 && guard < 200) begin
         chk("wb_wready", 32'(bus.wready), 32'd1);
         chk("wb_done_early", 32'(bus.done), 32'd0);
         if (gap_left > 0) begin
            bus.wvalid = 1'b0;
            bus.wdata  = $urandom;
            gap_left--;
         end else begin
            bus.wvalid = 1'b1;
            bus.wdata  = data[k];
         end
         fire = bus.wvalid & bus.wready;
         step();
         guard++;
         if (fire) begin
            ref_mem[widx(addr, k)] = data[k];
            k++;
            if (k < 8) gap_left = gaps[k];
         end
      end
      bus.wvalid = 1'b0;
      chk("wb_beats", k, 32'd8);
      chk("wb_done", 32'(bus.done), 32'd1);
      chk("wb_wready_off", 32'(bus.wready), 32'd0);
      chk("wb_done_req_ready", 32'(bus.req_ready), 32'd0);
      step();
      chk("wb_done_once", 32'(bus.done), 32'd0);
      chk("wb_idle_ready", 32'(bus.req_ready), 32'd1);
   endtask

   // mode 0: rready always 1; 1: pattern 1,0,0 repeating; 2: random.
   // abort_at >= 0 pulls reset while beat abort_at is presented.
   task automatic read_line(input logic [31:0] addr, input int mode, input logic hold,
                            input int abort_at, output int acc);
      int   k, guard, ph;
      logic rr;
      send_req(1'b0, addr, acc);
      if (!hold) bus.req_valid = 1'b0;
      for (int c = 1; c <= LAT; c++) begin
         chk("wait_rvalid", 32'(bus.rvalid), 32'd0);
         chk("wait_req_ready", 32'(bus.req_ready), 32'd0);
         bus.rready = 1'($urandom_range(0, 1));
         step();
      end
      chk("rvalid_first", 32'(bus.rvalid), 32'd1);
      k = 0;
      guard = 0;
      ph = 0;
      while (k < 8 && guard < 200) begin
         chk("rd_rvalid", 32'(bus.rvalid), 32'd1);
         chk("rd_data", bus.rdata, ref_mem[widx(addr, k)]);
         chk("rd_rlast", 32'(bus.rlast), 32'(k == 7));
         chk("rd_req_ready", 32'(bus.req_ready), 32'd0);
         chk("rd_done_early", 32'(bus.done), 32'd0);
         if (k == abort_at) begin
            #2;
            rst_n = 1'b0;
            #1;
            chk("rst_rdata", bus.rdata, 32'd0);
            chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
            chk("rst_rlast", 32'(bus.rlast), 32'd0);
            chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
            chk("rst_wready", 32'(bus.wready), 32'd0);
            chk("rst_done", 32'(bus.done), 32'd0);
            bus.rready = 1'b0;
            repeat (2) begin
               step();
               chk("rst_hold_done", 32'(bus.done), 32'd0);
            end
            @(negedge clk);
            rst_n = 1'b1;
            step();
            chk("rst_release_ready", 32'(bus.req_ready), 32'd1);
            chk("rst_release_done", 32'(bus.done), 32'd0);
            return;
         end
         case (mode)
            0:       rr = 1'b1;
            1:       rr = ((ph % 3) == 0);
            default: rr = 1'($urandom_range(0, 1));
         endcase
         ph++;
         bus.rready = rr;
         step();
         guard++;
         if (rr) k++;
      end
      bus.rready = 1'b0;
      chk("rd_beats", k, 32'd8);
      chk("rd_done", 32'(bus.done), 32'd1);
      chk("rd_rvalid_off", 32'(bus.rvalid), 32'd0);
      chk("rd_rlast_off", 32'(bus.rlast), 32'd0);
      chk("rd_done_req_ready", 32'(bus.req_ready), 32'd0);
      step();
      chk("rd_done_once", 32'(bus.done), 32'd0);
      chk("rd_idle_ready", 32'(bus.req_ready), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d [8];
      int          g [8];
      int          a1, a2;
      logic [31:0] addr;

      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_addr  = '0;
      bus.wdata     = '0;
      bus.wvalid    = 1'b0;
      bus.rready    = 1'b0;

      repeat (3) step();
      chk("reset_rdata", bus.rdata, 32'd0);
      chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
      chk("reset_wready", 32'(bus.wready), 32'd0);
      chk("reset_rvalid", 32'(bus.rvalid), 32'd0);
      chk("reset_rlast", 32'(bus.rlast), 32'd0);
      chk("reset_done", 32'(bus.done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("post_reset_ready", 32'(bus.req_ready), 32'd1);

      // Write then read with ignored low address bits.
      for (int k = 0; k < 8; k++) begin
         d[k] = 32'hA000_0000 + 32'(k);
         g[k] = 0;
      end
      write_line(32'h0000_0140, d, g);
      read_line(32'h0000_015C, 0, 1'b0, -1, a1);

      // Fill under backpressure.
      read_line(32'h0000_0140, 1, 1'b0, -1, a1);

      // Writeback with gaps before beats 2 and 5.
      for (int k = 0; k < 8; k++) begin
         d[k] = $urandom;
         g[k] = 0;
      end
      g[2] = 3;
      g[5] = 3;
      write_line(32'h0000_0A00, d, g);
      read_line(32'h0000_0A00, 0, 1'b0, -1, a1);

      // Aliasing past the top of the array.
      for (int k = 0; k < 8; k++) begin
         d[k] = $urandom;
         g[k] = 0;
      end
      write_line(32'h0000_0020, d, g);
      read_line(32'h0000_4020, 0, 1'b0, -1, a1);

      // Reset during beat 3 of a fill, then refill the same line.
      read_line(32'h0000_0020, 0, 1'b0, 3, a1);
      read_line(32'h0000_0020, 0, 1'b0, -1, a1);

      // Back-to-back fills with req_valid held high.
      read_line(32'h0000_0140, 0, 1'b1, -1, a1);
      read_line(32'h0000_0140, 0, 1'b1, -1, a2);
      bus.req_valid = 1'b0;
      chk("b2b_spacing", 32'(a2 - a1), 32'(LAT + 10));

      // Random lines, random gaps and random backpressure.
      repeat (6) begin
         addr = $urandom;
         for (int k = 0; k < 8; k++) begin
            d[k] = $urandom;
            g[k] = int'($urandom_range(0, 2));
         end
         write_line(addr, d, g);
         read_line(addr ^ 32'h0000_0013, 2, 1'b0, -1, a1);
      end
      read_line(32'h0000_0A00, 2, 1'b0, -1, a1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/line_mem_responder.md
Name: line_mem_responder

Overview:
- Memory-side responder for the OTTER 2-way data cache.
- Services the cache's line fills (reads) and dirty-line writebacks (writes).
- A line is 256 bits, moved as 8 beats of 32 bits over a valid/ready beat channel.
- Backed by an internal word-addressed array with a programmable access latency; stands in for main memory in cache bring-up and system simulation.

Parameters:
- ADDR_WORDS_LOG2, 12, log2 of array depth in 32-bit words (default 4096 words = 16 KiB).
- LATENCY, 4, cycles from request acceptance to the first beat of the burst; legal range 1..15.
- LINE_WORDS, 8, beats per line; fixed at 8, the cache line size. Not to be overridden.

Ports:
- CLK  in  1  clock, all logic on rising edge.
- RST_N  in  1  reset: asynchronous, active-low.
- req_valid  in  1  cache presents a line request.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  request type: 1 = writeback (write), 0 = fill (read).
- req_addr  in  32  byte address of the line; bits [4:0] ignored.
- wdata  in  32  writeback beat data.
- wvalid  in  1  writeback beat valid.
- wready  out  1  responder accepts a writeback beat.
- rdata  out  32  fill beat data.
- rvalid  out  1  fill beat valid.
- rready  in  1  cache accepts a fill beat.
- rlast  out  1  marks beat 7 of a fill; qualified by rvalid.
- done  out  1  one-cycle pulse when a request completes.

Behaviour:
- Reset (RST_N low) acts immediately, without waiting for a clock edge:
  - rdata = 0; req_ready, wready, rvalid, rlast and done all = 0.
  - State goes to IDLE; beat and latency counters clear.
  - Array contents are neither cleared nor modified.
- States: IDLE, WAIT, RBURST, WBURST, DONE.
- IDLE:
  - req_ready = 1; all other outputs 0.
  - Request accepted on an edge where req_valid & req_ready.
  - At acceptance, register base = {req_addr[ADDR_WORDS_LOG2+1:5], 3'b000} (word index) and we = req_we.
  - Next state: WAIT.
- WAIT:
  - Lasts exactly LATENCY cycles; req_ready = 0.
  - Exit to RBURST if we = 0, else WBURST.
  - First rvalid/wready is high in cycle LATENCY+1 after the acceptance edge (cycle 1 = the cycle right after that edge).
- RBURST:
  - Beat k (0..7) reads array[base+k].
  - rdata/rvalid are registered; the word is fetched at WAIT exit or at the previous beat's handshake.
  - rvalid stays high and rdata stays stable while rready = 0.
  - Beat advances on rvalid & rready; rready may be high every cycle, giving 1 beat/cycle.
  - rlast = 1 only with beat 7.
  - Handshake of beat 7 -> DONE.
- WBURST:
  - wready = 1 every cycle.
  - On wvalid & wready, array[base+k] <= wdata, and k increments.
  - Gaps in wvalid are legal; nothing is written on a gap.
  - 8th write -> DONE.
- DONE:
  - done = 1 for exactly one cycle; req_ready = 0; then IDLE.
  - Minimum request-to-request spacing is therefore LATENCY+8+2 cycles.
- Address rules:
  - Byte address bits [4:0] and bits above ADDR_WORDS_LOG2+1 are ignored, so out-of-range addresses alias modulo the array size.
  - Beat index is 3 bits; a burst never crosses a line boundary.
- Ignored inputs:
  - wvalid outside WBURST.
  - rready outside RBURST.
  - req_valid outside IDLE. The request is not latched; the cache must hold it until req_ready.
- Reset mid-burst: the burst is abandoned. Words already written remain; the remaining words are unchanged. No done pulse.
- A read of a never-written word returns X in simulation; the bench writes before reading.

Test Plan:
- Write then read, LATENCY=4:
  - Writeback to addr 0x0000_0140 with beats 0xA0000000+k, wvalid held high.
  - Required: wready first high in cycle 5 after acceptance; done pulses 1 cycle after the 8th beat.
  - Fill of 0x0000_015C (low bits ignored) returns 0xA0000000..0xA0000007 in order; rlast only on beat 7.
- Fill backpressure: rready toggled 1,0,0,1,... -> rdata/rvalid hold stable across stalls; exactly 8 beats, no duplicates or skips.
- Writeback gaps: wvalid low on beats 2 and 5 for 3 cycles each -> exactly 8 words written; readback matches; done only after the 8th write.
- Aliasing: with ADDR_WORDS_LOG2=12, write line at 0x0000_0020, fill from 0x0000_4020 -> identical data.
- Reset mid-fill:
  - Drop RST_N during beat 3 -> all outputs 0 asynchronously; no done pulse.
  - After release, req_ready = 1 the first cycle.
  - A new fill of the same line returns correct data.
- Back-to-back: req_valid held high for two fills -> second accepted exactly 1 cycle after done; req_ready low throughout WAIT, RBURST and DONE.
